// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern path: mode encodings, bar colours,
// control FSM states and default active-video timing.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_START_DEF  = 35;

  localparam logic [1:0] MODE_BARS   = 2'd0;
  localparam logic [1:0] MODE_CHECK  = 2'd1;
  localparam logic [1:0] MODE_GRAD   = 2'd2;
  localparam logic [1:0] MODE_BORDER = 2'd3;

  localparam logic [11:0] COL_WHITE   = 12'hFFF;
  localparam logic [11:0] COL_YELLOW  = 12'hFF0;
  localparam logic [11:0] COL_CYAN    = 12'h0FF;
  localparam logic [11:0] COL_GREEN   = 12'h0F0;
  localparam logic [11:0] COL_MAGENTA = 12'hF0F;
  localparam logic [11:0] COL_RED     = 12'hF00;
  localparam logic [11:0] COL_BLUE    = 12'h00F;
  localparam logic [11:0] COL_BLACK   = 12'h000;

  typedef enum logic {
    WAIT_FRAME,
    RUN
  } state_t;

  // Classic colour-bar order, left to right.
  function automatic logic [11:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = COL_WHITE;
      3'd1:    bar_color = COL_YELLOW;
      3'd2:    bar_color = COL_CYAN;
      3'd3:    bar_color = COL_GREEN;
      3'd4:    bar_color = COL_MAGENTA;
      3'd5:    bar_color = COL_RED;
      3'd6:    bar_color = COL_BLUE;
      default: bar_color = COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/pixel_pos_tracker.sv
// Recovers pixel column x and visible row y from the sync controller's V_SYNC and
// RGB_EN, and flags the vertical display window.
module pixel_pos_tracker #(
  parameter int V_START  = 35,
  parameter int V_ACTIVE = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       v_sync,
  input  logic       rgb_en,
  output logic       vs_fall,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       v_act
);

  localparam logic [9:0]  V_FIRST = 10'(V_START);
  localparam logic [10:0] V_END   = 11'(V_START + V_ACTIVE);

  logic       vs_reg;
  logic       en_reg;
  logic       en_fall;
  logic [9:0] line_cnt;

  assign vs_fall = vs_reg & ~v_sync;
  assign en_fall = en_reg & ~rgb_en;

  // vs_reg resets to the idle (high) sync level so reset release cannot fake an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_reg   <= 1'b1;
      en_reg   <= 1'b0;
      x        <= '0;
      line_cnt <= '0;
    end else begin
      vs_reg <= v_sync;
      en_reg <= rgb_en;

      if (!rgb_en)
        x <= '0;
      else if (x != 10'h3FF)
        x <= x + 10'd1;

      if (vs_fall)
        line_cnt <= '0;
      else if (en_fall && line_cnt != 10'h3FF)
        line_cnt <= line_cnt + 10'd1;
    end
  end

  assign v_act = (line_cnt >= V_FIRST) && ({1'b0, line_cnt} < V_END);
  assign y     = line_cnt - V_FIRST;

endmodule

// File: rtl/rgb_pattern_gen.sv
// Test-pattern generator behind the VGA sync controller: bars, checker, gradient, border.
// Define PATTERN_SCROLL_EN to make the checker scroll left one pixel per frame.
module rgb_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_START  = V_START_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int BAR_W    = 80
) (
  input  logic       CLK,
  input  logic       NRST,
  input  logic       H_SYNC,
  input  logic       V_SYNC,
  input  logic       RGB_EN,
  input  logic [1:0] MODE,
  output logic [3:0] RED,
  output logic [3:0] GREEN,
  output logic [3:0] BLUE,
  output logic       HS_OUT,
  output logic       VS_OUT,
  output logic [7:0] FRAME_CNT
);

  localparam logic [9:0] X_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_ACTIVE - 1);
  localparam logic [9:0] BAR_LAST = 10'(BAR_W - 1);

  state_t      state_reg, state_next;
  logic        pix_on;
  logic        vs_fall;
  logic        v_act;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        cx5;
  logic [9:0]  bar_px_reg;
  logic [2:0]  bar_idx_reg;
  logic [1:0]  mode_reg;
  logic [11:0] color;

  pixel_pos_tracker #(
    .V_START  (V_START),
    .V_ACTIVE (V_ACTIVE)
  ) u_tracker (
    .clk     (CLK),
    .rst_n   (NRST),
    .v_sync  (V_SYNC),
    .rgb_en  (RGB_EN),
    .vs_fall (vs_fall),
    .x       (x),
    .y       (y),
    .v_act   (v_act)
  );

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST)
      state_reg <= WAIT_FRAME;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    pix_on     = 1'b0;
    case (state_reg)
      WAIT_FRAME: if (vs_fall) state_next = RUN;
      RUN:        pix_on = RGB_EN && v_act;
      default:    state_next = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      mode_reg    <= MODE_BARS;
      FRAME_CNT   <= '0;
      bar_px_reg  <= '0;
      bar_idx_reg <= '0;
    end else begin
      if (vs_fall) begin
        mode_reg  <= MODE;
        FRAME_CNT <= FRAME_CNT + 8'd1;
      end

      if (!RGB_EN) begin
        bar_px_reg  <= '0;
        bar_idx_reg <= '0;
      end else if (bar_px_reg == BAR_LAST) begin
        bar_px_reg <= '0;
        if (bar_idx_reg != 3'd7)
          bar_idx_reg <= bar_idx_reg + 3'd1;
      end else begin
        bar_px_reg <= bar_px_reg + 10'd1;
      end
    end
  end

`ifdef PATTERN_SCROLL_EN
  // Bit 5 of (x + FRAME_CNT); only that bit selects the checker square.
  assign cx5 = x[5] ^ FRAME_CNT[5] ^ (({1'b0, x[4:0]} + {1'b0, FRAME_CNT[4:0]}) > 6'd31);
`else
  assign cx5 = x[5];
`endif

  always_comb begin
    color = COL_BLACK;
    case (mode_reg)
      MODE_BARS:  color = bar_color(bar_idx_reg);
      MODE_CHECK: color = (cx5 ^ y[5]) ? COL_WHITE : COL_BLACK;
      MODE_GRAD:  color = {x[8:5], y[8:5], FRAME_CNT[5:2]};
      default:    color = (x == 10'd0 || x == X_LAST || y == 10'd0 || y == Y_LAST)
                          ? COL_WHITE : COL_BLACK;
    endcase
    if (!pix_on)
      color = COL_BLACK;
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      RED    <= '0;
      GREEN  <= '0;
      BLUE   <= '0;
      HS_OUT <= 1'b1;
      VS_OUT <= 1'b1;
    end else begin
      RED    <= color[11:8];
      GREEN  <= color[7:4];
      BLUE   <= color[3:0];
      HS_OUT <= H_SYNC;
      VS_OUT <= V_SYNC;
    end
  end

endmodule

// File: tb/tb_rgb_pattern_gen.sv
// Directed bench for rgb_pattern_gen: drives compact sync timing and checks chosen
// pixels against hand-computed colours.
module tb_rgb_pattern_gen;

  logic       CLK = 1'b0;
  logic       NRST;
  logic       H_SYNC;
  logic       V_SYNC;
  logic       RGB_EN;
  logic [1:0] MODE;
  logic [3:0] RED;
  logic [3:0] GREEN;
  logic [3:0] BLUE;
  logic       HS_OUT;
  logic       VS_OUT;
  logic [7:0] FRAME_CNT;

  int n_checks = 0;
  int n_fail   = 0;
  int cur_line = 0;

  int          chk_x [16];
  logic [11:0] chk_c [16];
  int          chk_n = 0;

  always #5 CLK = ~CLK;

  rgb_pattern_gen dut (
    .CLK       (CLK),
    .NRST      (NRST),
    .H_SYNC    (H_SYNC),
    .V_SYNC    (V_SYNC),
    .RGB_EN    (RGB_EN),
    .MODE      (MODE),
    .RED       (RED),
    .GREEN     (GREEN),
    .BLUE      (BLUE),
    .HS_OUT    (HS_OUT),
    .VS_OUT    (VS_OUT),
    .FRAME_CNT (FRAME_CNT)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [11:0] rgb();
    return {RED, GREEN, BLUE};
  endfunction

  task automatic add_chk(input int xp, input logic [11:0] c);
    chk_x[chk_n] = xp;
    chk_c[chk_n] = c;
    chk_n++;
  endtask

  // One line: sync pulse, back porch, n_px enabled pixels, one blank cycle.
  task automatic hline(input int n_px, input string tag);
    int k;
    bit chk;
    k   = 0;
    chk = (chk_n > 0);
    if (chk) check_eq({tag, " hs_pre"}, 32'(HS_OUT), 32'd1);
    H_SYNC = 1'b0;
    tick;
    if (chk) check_eq({tag, " hs_lag"}, 32'(HS_OUT), 32'd0);
    H_SYNC = 1'b1;
    tick;
    if (chk) check_eq({tag, " blank_pre"}, 32'(rgb()), 32'h000);
    RGB_EN = 1'b1;
    for (int i = 0; i < n_px; i++) begin
      tick;
      if (k < chk_n && chk_x[k] == i) begin
        check_eq($sformatf("%s x=%0d", tag, i), 32'(rgb()), 32'(chk_c[k]));
        k++;
      end
    end
    RGB_EN = 1'b0;
    tick;
    if (chk) check_eq({tag, " blank_post"}, 32'(rgb()), 32'h000);
    cur_line++;
    chk_n = 0;
  endtask

  task automatic lines_to(input int target);
    while (cur_line < target) hline(1, "fill");
  endtask

  task automatic vsync;
    V_SYNC = 1'b0;
    tick;
    tick;
    V_SYNC = 1'b1;
    tick;
    cur_line = 0;
  endtask

  initial begin
    NRST   = 1'b0;
    H_SYNC = 1'b0;
    V_SYNC = 1'b0;
    RGB_EN = 1'b1;
    MODE   = 2'd0;
    tick;
    tick;
    check_eq("rst rgb", 32'(rgb()), 32'h000);
    check_eq("rst hs_out", 32'(HS_OUT), 32'd1);
    check_eq("rst vs_out", 32'(VS_OUT), 32'd1);
    check_eq("rst frame_cnt", 32'(FRAME_CNT), 32'd0);
    H_SYNC = 1'b1;
    V_SYNC = 1'b1;
    RGB_EN = 1'b0;
    tick;
    NRST = 1'b1;
    tick;

    // Run into a frame, then reset asynchronously in the middle of a visible line.
    vsync;
    check_eq("frame A cnt", 32'(FRAME_CNT), 32'd1);
    lines_to(35);
    add_chk(0, 12'hFFF);
    hline(1, "frame A row0");
    H_SYNC = 1'b0;
    tick;
    H_SYNC = 1'b1;
    tick;
    RGB_EN = 1'b1;
    tick;
    check_eq("pre-reset px", 32'(rgb()), 32'hFFF);
    NRST = 1'b0;
    #1;
    check_eq("async rst rgb", 32'(rgb()), 32'h000);
    check_eq("async rst frame_cnt", 32'(FRAME_CNT), 32'd0);
    RGB_EN = 1'b0;
    tick;
    tick;
    NRST = 1'b1;
    tick;
    cur_line = 0;
    lines_to(35);
    add_chk(0, 12'h000);
    add_chk(5, 12'h000);
    hline(8, "wait_frame");

    // Frame 1: colour bars.
    vsync;
    check_eq("frame 1 cnt", 32'(FRAME_CNT), 32'd1);
    lines_to(34);
    add_chk(0, 12'h000);
    hline(4, "line34");
    add_chk(0, 12'hFFF);
    add_chk(79, 12'hFFF);
    add_chk(80, 12'hFF0);
    add_chk(159, 12'hFF0);
    add_chk(160, 12'h0FF);
    add_chk(240, 12'h0F0);
    add_chk(320, 12'hF0F);
    add_chk(400, 12'hF00);
    add_chk(480, 12'h00F);
    add_chk(560, 12'h000);
    add_chk(639, 12'h000);
    add_chk(640, 12'h000);
    add_chk(699, 12'h000);
    hline(700, "bars");
    MODE = 2'd1;
    add_chk(80, 12'hFF0);
    add_chk(600, 12'h000);
    hline(640, "bars after mode chg");
    lines_to(1059);
    add_chk(0, 12'h000);
    hline(2, "line sat");

    // Frame 2: checker.
    vsync;
    lines_to(35);
    add_chk(0, 12'h000);
    add_chk(16, 12'h000);
    add_chk(32, 12'hFFF);
    add_chk(48, 12'hFFF);
    add_chk(64, 12'h000);
    hline(65, "check y0");
    lines_to(67);
    add_chk(0, 12'hFFF);
    add_chk(32, 12'h000);
    hline(33, "check y32");
    MODE = 2'd2;

    // Frame 3: gradient (FRAME_CNT=3 so blue is 0).
    vsync;
    lines_to(35);
    add_chk(0, 12'h000);
    add_chk(100, 12'h300);
    add_chk(320, 12'hA00);
    add_chk(480, 12'hF00);
    add_chk(1030, 12'hF00);
    hline(1040, "grad y0");
    lines_to(135);
    add_chk(480, 12'hF30);
    hline(481, "grad y100");
    MODE = 2'd3;

    // Frame 4: border.
    vsync;
    lines_to(35);
    add_chk(0, 12'hFFF);
    add_chk(100, 12'hFFF);
    add_chk(639, 12'hFFF);
    add_chk(640, 12'hFFF);
    hline(641, "border y0");
    lines_to(135);
    add_chk(0, 12'hFFF);
    add_chk(1, 12'h000);
    add_chk(638, 12'h000);
    add_chk(639, 12'hFFF);
    add_chk(640, 12'h000);
    hline(641, "border y100");
    lines_to(514);
    add_chk(0, 12'hFFF);
    add_chk(300, 12'hFFF);
    add_chk(639, 12'hFFF);
    hline(640, "border y479");
    add_chk(300, 12'h000);
    hline(301, "past last row");
    MODE = 2'd1;

    // Frame counter to 32, checker at the origin (scroll-dependent).
    repeat (28) vsync;
    check_eq("frame_cnt 32", 32'(FRAME_CNT), 32'd32);
    lines_to(35);
`ifdef PATTERN_SCROLL_EN
    add_chk(0, 12'hFFF);
    add_chk(16, 12'hFFF);
    add_chk(48, 12'h000);
`else
    add_chk(0, 12'h000);
    add_chk(16, 12'h000);
    add_chk(48, 12'hFFF);
`endif
    hline(49, "check frame32");
    repeat (223) vsync;
    check_eq("frame_cnt 255", 32'(FRAME_CNT), 32'd255);
    vsync;
    check_eq("frame_cnt wrap", 32'(FRAME_CNT), 32'd0);
    MODE = 2'd2;
    repeat (20) vsync;
    check_eq("frame_cnt 20", 32'(FRAME_CNT), 32'd20);
    lines_to(35);
    add_chk(320, 12'hA05);
    hline(321, "grad blue");

    // V_SYNC fall coinciding with RGB_EN fall: the line clear must win.
    MODE = 2'd0;
    H_SYNC = 1'b0;
    tick;
    H_SYNC = 1'b1;
    tick;
    RGB_EN = 1'b1;
    tick;
    tick;
    check_eq("vs_out pre", 32'(VS_OUT), 32'd1);
    V_SYNC = 1'b0;
    RGB_EN = 1'b0;
    tick;
    check_eq("vs_out lag", 32'(VS_OUT), 32'd0);
    tick;
    V_SYNC = 1'b1;
    tick;
    cur_line = 0;
    check_eq("coinc frame_cnt", 32'(FRAME_CNT), 32'd21);
    lines_to(34);
    add_chk(0, 12'h000);
    hline(2, "coinc line34");
    add_chk(0, 12'hFFF);
    hline(2, "coinc line35");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
